spi_reg_bridge: RTL
===================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, is the byte loaded for transmission at every frame start.
REQ-002 Parameter ADDR_W, default 7, is the register address width; it SHALL NOT exceed 7.
REQ-003 i_sys_clk  in  1  system clock; every flop is clocked on its rising edge.
REQ-004 i_sys_rst_n  in  1  reset, asynchronous, active low.
REQ-005 i_ssn  in  1  SPI slave select, active low; low marks a frame.
REQ-006 i_rx_data  in  8  received byte from the SPI slave.
REQ-007 i_rx_ready  in  1  SPI slave receiver ready (level).
REQ-008 i_tx_ready  in  1  SPI slave transmitter ready (level).
REQ-009 o_csn  out  1  SPI slave local select; constant 0 out of reset.
REQ-010 o_tx_data  out  8  byte to transmit.
REQ-011 o_tx_wr  out  1  one-cycle write strobe for o_tx_data.
REQ-012 o_rx_rd  out  1  one-cycle read acknowledge for the received byte.
REQ-013 o_reg_addr  out  ADDR_W  register address.
REQ-014 o_reg_wdata  out  8  register write data.
REQ-015 o_reg_wr  out  1  one-cycle register write strobe.
REQ-016 o_reg_rd  out  1  one-cycle register read strobe.
REQ-017 i_reg_rdata  in  8  register read data; valid the cycle after o_reg_rd.
REQ-018 o_tx_overrun  out  1  sticky flag: a transmit write was attempted while i_tx_ready was 0.
REQ-019 o_frame_cnt  out  16  count of completed frames.

Function
REQ-020 A byte strobe SHALL be a registered rising edge of i_rx_ready qualified by i_ssn=0; it SHALL occur one cycle after the edge is sampled, and o_rx_rd SHALL pulse in the same cycle.
REQ-021 The FSM SHALL have the states IDLE, CMD, WRITE, READ_REQ, READ_LOAD and READ_WAIT.
REQ-022 IDLE->CMD SHALL occur on the falling edge of i_ssn; in that cycle o_tx_wr SHALL pulse with o_tx_data=SYNC_BYTE.
REQ-023 In CMD, a byte strobe SHALL capture the command: bit7=1 means read, bit7=0 means write; bits[ADDR_W-1:0] load o_reg_addr.
REQ-024 CMD with a write command SHALL go to WRITE.
REQ-025 CMD with a read command SHALL go to READ_REQ.
REQ-026 In WRITE, each byte strobe SHALL drive o_reg_wdata=byte and pulse o_reg_wr for one cycle; o_reg_addr SHALL increment in the following cycle.
REQ-027 In READ_REQ, o_reg_rd SHALL pulse for one cycle, then the FSM SHALL go to READ_LOAD.
REQ-028 In READ_LOAD, i_reg_rdata SHALL be loaded into o_tx_data, o_tx_wr SHALL pulse, and o_reg_addr SHALL increment; the FSM SHALL then go to READ_WAIT.
REQ-029 Latency from the command byte strobe to o_tx_wr SHALL be 2 cycles.
REQ-030 In READ_WAIT, each byte strobe (dummy byte, data ignored) SHALL cause a transition to READ_REQ, giving auto-increment burst reads.
REQ-031 Address increment SHALL wrap from 2^ADDR_W-1 to 0 with no flag.
REQ-032 Any o_tx_wr pulse issued while i_tx_ready=0 SHALL set o_tx_overrun; the write still issues.
REQ-033 o_tx_overrun SHALL be cleared only by reset.
REQ-034 A rising edge of i_ssn in any non-IDLE state SHALL force IDLE on the next cycle, with no further strobes and any in-flight read abandoned.
REQ-035 o_frame_cnt SHALL increment by 1 on that rising edge if at least one command byte was received, and SHALL wrap at 16'hFFFF.
REQ-036 A strobe coinciding with the i_ssn rising edge SHALL be discarded.
REQ-037 At most one of o_reg_wr, o_reg_rd and o_tx_wr SHALL be high in any cycle.

Reset
REQ-038 While i_sys_rst_n=0, all outputs SHALL be 0 and the FSM SHALL be IDLE.
REQ-039 Edge-detect registers SHALL reset to 0, and i_ssn history SHALL reset to 1.
REQ-040 Reset asserted mid-frame SHALL abort the frame without incrementing o_frame_cnt.
REQ-041 After reset release, the block SHALL wait for the next i_ssn falling edge.

Verification
REQ-042 Write frame: ssn low, bytes 0x05, 0x11, 0x22 -> o_tx_wr with 0xA5 at the frame start; o_reg_wr at addr 0x05 with data 0x11, then at addr 0x06 with data 0x22; o_frame_cnt=1 after ssn high.
REQ-043 Read burst: bytes 0x83, 0x00, 0x00 with rdata = addr+0x40 -> o_reg_rd at addresses 3, 4, 5; o_tx_data 0x43, 0x44, 0x45; each o_tx_wr occurs 2 cycles after its strobe.
REQ-044 Wrap: write command 0x7F, then 2 data bytes -> writes at addresses 0x7F and 0x00.
REQ-045 Abort: ssn rises 1 cycle after the read command strobe -> FSM in IDLE next cycle; no o_tx_wr for read data; o_frame_cnt still increments.
REQ-046 Overrun: i_tx_ready held 0 at the frame start -> o_tx_overrun=1, and it stays set across the next frame until reset.
REQ-047 Reset mid-write burst -> all outputs 0; o_frame_cnt unchanged at 0; the next frame decodes normally.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI slave byte stream to register bus bridge.
// Frame start sends SYNC_BYTE; cmd byte bit7 selects read/write,
// low bits load the address; data bytes write or burst-read with
// auto-increment.
// Ports: i_sys_clk/i_sys_rst_n clock and async low reset;
//   i_ssn, i_rx_data, i_rx_ready, i_tx_ready, o_csn, o_tx_data,
//   o_tx_wr, o_rx_rd to the SPI slave; o_reg_addr, o_reg_wdata,
//   o_reg_wr, o_reg_rd, i_reg_rdata to the register file;
//   o_tx_overrun sticky status, o_frame_cnt completed frames.
module spi_reg_bridge #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 7
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst_n,
  input  logic              i_ssn,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_ready,
  input  logic              i_tx_ready,
  output logic              o_csn,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_wr,
  output logic              o_rx_rd,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_tx_overrun,
  output logic [15:0]       o_frame_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ_REQ,
    READ_LOAD,
    READ_WAIT
  } state_t;

  state_t state, state_nx;

  logic              ssn_q;
  logic              rx_q;
  logic              fall_q;
  logic              strb;
  logic              rx_edge;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_q;
  logic [ADDR_W-1:0] addr;
  logic              got_cmd;
  logic              ovr;
  logic [15:0]       cnt;

  logic              ssn_rise;
  logic              byte_ok;
  logic              abort;
  logic              tx_wr;
  logic [7:0]        tx_now;
  logic              reg_wr;
  logic              reg_rd;
  logic              ld_addr;
  logic              inc_addr;

  // Rising edge of i_ssn is taken straight from the pin so the
  // abort lands on the very next cycle; a byte strobe that meets
  // it is dropped.
  assign rx_edge  = i_rx_ready & ~rx_q & ~i_ssn;
  assign ssn_rise = i_ssn & ~ssn_q;
  assign byte_ok  = strb & ~ssn_rise;
  assign abort    = ssn_rise & (state != IDLE);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      ssn_q   <= 1'b1;
      rx_q    <= 1'b0;
      fall_q  <= 1'b0;
      strb    <= 1'b0;
      rx_byte <= '0;
    end else begin
      ssn_q  <= i_ssn;
      rx_q   <= i_rx_ready;
      fall_q <= ssn_q & ~i_ssn;
      strb   <= rx_edge;
      if (rx_edge) rx_byte <= i_rx_data;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) state <= IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_wr    = 1'b0;
    tx_now   = tx_q;
    reg_wr   = 1'b0;
    reg_rd   = 1'b0;
    ld_addr  = 1'b0;
    inc_addr = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall_q) begin
          state_nx = CMD;
          tx_wr    = 1'b1;
          tx_now   = SYNC_BYTE;
        end
      end
      CMD: begin
        if (byte_ok) begin
          ld_addr  = 1'b1;
          state_nx = rx_byte[7] ? READ_REQ : WRITE;
        end
      end
      WRITE: begin
        if (byte_ok) begin
          reg_wr   = 1'b1;
          inc_addr = 1'b1;
        end
      end
      READ_REQ: begin
        reg_rd   = 1'b1;
        state_nx = READ_LOAD;
      end
      READ_LOAD: begin
        tx_wr    = 1'b1;
        tx_now   = i_reg_rdata;
        inc_addr = 1'b1;
        state_nx = READ_WAIT;
      end
      READ_WAIT: begin
        if (byte_ok) state_nx = READ_REQ;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      addr    <= '0;
      tx_q    <= '0;
      got_cmd <= 1'b0;
      ovr     <= 1'b0;
      cnt     <= '0;
    end else begin
      if (ld_addr)       addr <= rx_byte[ADDR_W-1:0];
      else if (inc_addr) addr <= addr + ADDR_W'(1);
      if (tx_wr) tx_q <= tx_now;
      if (tx_wr && !i_tx_ready) ovr <= 1'b1;
      if (abort) begin
        got_cmd <= 1'b0;
        if (got_cmd) cnt <= cnt + 16'd1;
      end else if (ld_addr) begin
        got_cmd <= 1'b1;
      end
    end
  end

  assign o_csn        = 1'b0;
  assign o_tx_data    = tx_now;
  assign o_tx_wr      = tx_wr;
  assign o_rx_rd      = strb;
  assign o_reg_addr   = addr;
  assign o_reg_wdata  = rx_byte;
  assign o_reg_wr     = reg_wr;
  assign o_reg_rd     = reg_rd;
  assign o_tx_overrun = ovr;
  assign o_frame_cnt  = cnt;

endmodule
